// File: rtl/c_xbar_alloc_pkg.sv
// Shared types and sizing helpers for the crossbar allocator.
// Latency: n/a (types only). Backpressure: n/a.
// Holds the per-output FSM state encoding and the watchdog counter width.
package c_xbar_alloc_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } op_state_t;

    function automatic int wdog_cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/c_interleave.sv
// Matrix transpose: regroups num_blocks blocks of width/num_blocks bits by bit position.
// Latency: combinational. Backpressure: none (pure wiring).
// Output bit i*num_blocks+j comes from input bit j*(width/num_blocks)+i.
module c_interleave #(
    parameter int width      = 2,
    parameter int num_blocks = 2
) (
    input  logic [0:width-1] data_in,
    output logic [0:width-1] data_out
);

    localparam int step = width / num_blocks;

    for (genvar i = 0; i < step; i++) begin : g_pos
        for (genvar j = 0; j < num_blocks; j++) begin : g_blk
            assign data_out[i*num_blocks+j] = data_in[j*step+i];
        end
    end

endmodule

// File: rtl/c_xbar_alloc_op.sv
// One output's allocator: round-robin lock FSM, grant register, optional watchdog (C_XBAR_ALLOC_WDOG_EN).
// Latency: grant 1 cycle after request; xfer combinational from registered state and current req/ready.
// Backpressure: ready low stalls the locked packet but never blocks arbitration.
module c_xbar_alloc_op
    import c_xbar_alloc_pkg::*;
#(
    parameter int num_in_ports = 5,
    parameter int wdog_limit   = 255
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [0:num_in_ports-1] req_ip,
    input  logic [0:num_in_ports-1] tail_ip,
    input  logic                    ready,
    output logic [0:num_in_ports-1] gnt_ip,
    output logic                    xfer,
    output logic                    error
);

    localparam int PW = idx_width(num_in_ports);

    op_state_t               state_q, state_d;
    logic [0:num_in_ports-1] gnt_q, gnt_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [PW-1:0]           win;
    logic                    found;
    logic                    req_g;
    logic                    tail_g;
    int                      idx;

    assign req_g  = |(gnt_q & req_ip);
    assign tail_g = |(gnt_q & tail_ip);
    assign xfer   = (state_q == ST_LOCKED) && ready && req_g;
    assign gnt_ip = gnt_q;

    // Round-robin search starting at ptr_q, wrapping at num_in_ports.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < num_in_ports; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= num_in_ports) idx = idx - num_in_ports;
            if (!found && req_ip[idx]) begin
                win   = PW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d    = ST_LOCKED;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    ptr_d      = (int'(win) == num_in_ports - 1) ? '0 : win + PW'(1);
                end
            end
            default: begin
                // Tail transfer and requester abort both collapse to one release.
                if (!req_g || (xfer && tail_g)) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef C_XBAR_ALLOC_WDOG_EN
    localparam int            CW    = wdog_cnt_width(wdog_limit);
    localparam logic [CW-1:0] LIMIT = CW'(wdog_limit);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          error_q, error_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != ST_LOCKED || state_d != ST_LOCKED || xfer) begin
            cnt_d = '0;
        end else if (!ready && cnt_q != LIMIT) begin
            cnt_d = cnt_q + CW'(1);
        end
        error_d = error_q | (cnt_d == LIMIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    // Watchdog compiled out: the limit can never be negative, so the flag is constant low.
    assign error = (wdog_limit < 0);
`endif

endmodule

// File: rtl/c_xbar_alloc.sv
// Crossbar switch allocator: one independent lock FSM per output; watchdog gated by C_XBAR_ALLOC_WDOG_EN.
// Latency: gnt_ip_op registered, 1 cycle after request; xfer_op combinational.
// Backpressure: ready_op only gates xfer_op and holds the lock; arbitration ignores it.
module c_xbar_alloc
    import c_xbar_alloc_pkg::*;
#(
    parameter int num_in_ports  = 5,
    parameter int num_out_ports = 5,
    parameter int wdog_limit    = 255
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [0:num_in_ports*num_out_ports-1] req_ip_op,
    input  logic [0:num_in_ports-1]               tail_ip,
    input  logic [0:num_out_ports-1]              ready_op,
    output logic [0:num_in_ports*num_out_ports-1] gnt_ip_op,
    output logic [0:num_out_ports-1]              xfer_op,
    output logic [0:num_out_ports-1]              error_op
);

    localparam int NW = num_in_ports * num_out_ports;

    logic [0:NW-1] req_op_ip;
    logic [0:NW-1] gnt_op_ip;

    // Requests arrive grouped by input; each output FSM wants its column.
    c_interleave #(
        .width      (NW),
        .num_blocks (num_in_ports)
    ) u_req_xpose (
        .data_in  (req_ip_op),
        .data_out (req_op_ip)
    );

    for (genvar op = 0; op < num_out_ports; op++) begin : g_op
        c_xbar_alloc_op #(
            .num_in_ports (num_in_ports),
            .wdog_limit   (wdog_limit)
        ) u_op (
            .clk     (clk),
            .reset_n (reset_n),
            .req_ip  (req_op_ip[op*num_in_ports +: num_in_ports]),
            .tail_ip (tail_ip),
            .ready   (ready_op[op]),
            .gnt_ip  (gnt_op_ip[op*num_in_ports +: num_in_ports]),
            .xfer    (xfer_op[op]),
            .error   (error_op[op])
        );
    end

    c_interleave #(
        .width      (NW),
        .num_blocks (num_out_ports)
    ) u_gnt_xpose (
        .data_in  (gnt_op_ip),
        .data_out (gnt_ip_op)
    );

endmodule

// File: doc/c_xbar_alloc.md
C_XBAR_ALLOC -- requirements
Module: c_xbar_alloc

Interface
REQ-001 SHALL have parameter num_in_ports, default 5, number of crossbar inputs.
REQ-002 SHALL have parameter num_out_ports, default 5, number of crossbar outputs.
REQ-003 SHALL have parameter wdog_limit, default 255, stall-cycle threshold for the watchdog.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_ip_op  input  [0:num_in_ports*num_out_ports-1]  bit ip*num_out_ports+op set: input ip requests output op.
REQ-007 tail_ip  input  [0:num_in_ports-1]  current flit at input ip is a packet tail.
REQ-008 ready_op  input  [0:num_out_ports-1]  output op accepts a flit this cycle.
REQ-009 gnt_ip_op  output  [0:num_in_ports*num_out_ports-1]  registered grant, same bit order as req_ip_op; drives the crossbar control matrix directly.
REQ-010 xfer_op  output  [0:num_out_ports-1]  flit moves through output op this cycle.
REQ-011 error_op  output  [0:num_out_ports-1]  sticky watchdog flag (Configuration).

Function
REQ-012 Each output SHALL run an independent FSM with states IDLE and LOCKED.
REQ-013 Per output, at most one gnt_ip_op bit SHALL be set in any cycle; one input may hold grants on several outputs (multicast).
REQ-014 IDLE, any req for op in cycle t: pick winner by round-robin from pointer ptr_op upward, modulo num_in_ports; at t+1, winner's gnt bit set, state LOCKED.
REQ-015 Arbitration SHALL NOT depend on ready_op; an output may lock while not ready.
REQ-016 On grant to input k, ptr_op SHALL become (k+1) mod num_in_ports.
REQ-017 xfer_op = state LOCKED and ready_op[op] and req of granted input; combinational from registered state.
REQ-018 LOCKED, xfer_op and tail_ip[granted] in cycle t: gnt cleared and state IDLE at t+1; new grant earliest at t+2 (one bubble).
REQ-019 LOCKED, granted input drops its req: gnt cleared and state IDLE next cycle (abort); ptr_op unchanged.
REQ-020 LOCKED, non-tail transfer or stall: gnt held unchanged.
REQ-021 Requests from non-granted inputs SHALL be ignored while LOCKED.
REQ-022 Tail and abort same cycle SHALL behave as a single release.

Reset
REQ-023 While reset_n low: all FSMs IDLE, gnt_ip_op zero, xfer_op zero, all ptr_op zero, error_op zero, watchdog counters zero.
REQ-024 Reset asserted mid-packet SHALL drop grants immediately (asynchronously), without waiting for a tail.

Configuration
REQ-025 Macro C_XBAR_ALLOC_WDOG_EN SHALL gate the watchdog.
REQ-026 With it defined: per-output counter, width clog2(wdog_limit+1), increments each LOCKED cycle with ready_op low, clears on transfer or leaving LOCKED, saturates; reaching wdog_limit sets error_op[op] until reset.
REQ-027 Without it: no counters; error_op tied to zero; all other behaviour identical.

Structure
REQ-028 FSM state enum and the watchdog counter width function SHALL live in shared package c_xbar_alloc_pkg.
REQ-029 Per-output FSM, pointer and watchdog SHALL be sub-module c_xbar_alloc_op, instantiated num_out_ports times in a generate loop.
REQ-030 Request-matrix transposition SHALL use the existing c_interleave block.

Verification
REQ-031 Reset, then input 2 requests output 0, ready high -> gnt bit 2*5+0 high one cycle later; xfer_op[0] high.
REQ-032 Inputs 1,3 request output 4 with ptr 0 -> input 1 granted; after its tail transfers, one idle cycle, then input 3 granted.
REQ-033 3-flit packet with ready_op[0] low in the middle cycle -> grant held 4 cycles, xfer_op[0] high exactly 3 cycles.
REQ-034 Input 0 requests outputs 1 and 2 simultaneously -> both grants set same cycle, independent release on tail.
REQ-035 reset_n pulled low mid-packet -> gnt_ip_op zero with no clock edge; after release, arbitration restarts from input 0.
REQ-036 With C_XBAR_ALLOC_WDOG_EN and wdog_limit=4, locked output stalled 4 cycles -> error_op set and stays set after transfer resumes; without the macro, error_op stays 0.
